// File: rtl/eth_udp_tx_sched.sv
// Round-robin scheduler sharing one GMII UDP TX engine among four payload sources.
// Arbitrates in IDLE, launches the engine, steers byte requests in BUSY, then holds an IFG.
module eth_udp_tx_sched #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [15:0] MAX_LEN        = 16'd1472,
  parameter int unsigned IFG_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk125m,
  input  logic                   reset_p,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [16*NUM_CH-1:0]   ch_len,
  input  logic [16*NUM_CH-1:0]   ch_port,
  input  logic [8*NUM_CH-1:0]    ch_dat,
  output logic [NUM_CH-1:0]      ch_rd,
  output logic [NUM_CH-1:0]      ch_start,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [NUM_CH-1:0]      ch_err,
  output logic                   tx_en_pulse,
  output logic [15:0]            data_length,
  output logic [15:0]            dst_port,
  input  logic                   payload_req_i,
  output logic [7:0]             payload_dat_o,
  input  logic                   tx_done,
  output logic                   busy
);

  localparam int unsigned PTR_W        = $clog2(NUM_CH);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] IFG_LAST     = 16'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant;
  logic [15:0]        cnt;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic [15:0]        win_len;
  logic [15:0]        win_port;
  logic               win_legal;

  // First requesting channel at or after rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = rr_ptr + PTR_W'(k);
      if (!win_found && ch_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_len   = ch_len[16*win_idx +: 16];
  assign win_port  = ch_port[16*win_idx +: 16];
  assign win_legal = (win_len != 16'd0) && (win_len <= MAX_LEN);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; tx_done wins over a timeout landing in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found && win_legal) state_next = LAUNCH;
      LAUNCH:  state_next = BUSY;
      BUSY:    if (tx_done || cnt == TIMEOUT_LAST) state_next = GAP;
      GAP:     if (cnt == IFG_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational byte steering, live only while the engine is streaming.
  always_comb begin
    ch_rd         = '0;
    payload_dat_o = '0;
    if (state == BUSY) begin
      ch_rd[grant]  = payload_req_i;
      payload_dat_o = ch_dat[8*grant +: 8];
    end
  end

  // Registered control outputs, grant bookkeeping and the shared timeout/IFG counter.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      rr_ptr      <= '0;
      grant       <= '0;
      cnt         <= '0;
      data_length <= '0;
      dst_port    <= '0;
      tx_en_pulse <= 1'b0;
      ch_start    <= '0;
      ch_done     <= '0;
      ch_err      <= '0;
      busy        <= 1'b0;
    end else begin
      tx_en_pulse <= 1'b0;
      ch_start    <= '0;
      ch_done     <= '0;
      ch_err      <= '0;
      busy        <= (state_next != IDLE);

      case (state)
        IDLE: begin
          if (win_found) begin
            rr_ptr <= win_idx + 1'b1;
            if (win_legal) begin
              grant             <= win_idx;
              data_length       <= win_len;
              dst_port          <= win_port;
              tx_en_pulse       <= 1'b1;
              ch_start[win_idx] <= 1'b1;
            end else begin
              ch_err[win_idx] <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (tx_done)                  ch_done[grant] <= 1'b1;
          else if (cnt == TIMEOUT_LAST) ch_err[grant]  <= 1'b1;
        end
        default: ;
      endcase

      // Counter restarts on every state change, so it measures time spent in BUSY or GAP.
      if (state_next == state && (state == BUSY || state == GAP)) cnt <= cnt + 16'd1;
      else                                                        cnt <= '0;
    end
  end

endmodule

// File: tb/tb_eth_udp_tx_sched.sv
// Directed scoreboard bench for eth_udp_tx_sched: launch order, lengths, ports, IFG,
// length rejection, timeout, mid-frame disturbance and asynchronous reset.
module tb_eth_udp_tx_sched;

  localparam int IFG = 16;
  localparam int TMO = 4096;

  logic        clk125m = 1'b0;
  logic        reset_p = 1'b1;
  logic [3:0]  ch_req;
  logic [63:0] ch_len;
  logic [63:0] ch_port;
  logic [31:0] ch_dat;
  logic [3:0]  ch_rd, ch_start, ch_done, ch_err;
  logic        tx_en_pulse;
  logic [15:0] data_length, dst_port;
  logic        payload_req_i;
  logic [7:0]  payload_dat_o;
  logic        tx_done;
  logic        busy;

  typedef struct {
    int          ch;
    int          len;
    logic [15:0] port;
  } launch_t;

  launch_t sb[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc    = 0;

  always #4 clk125m = ~clk125m;
  always @(posedge clk125m) cyc <= cyc + 1;

  eth_udp_tx_sched dut (
    .clk125m       (clk125m),
    .reset_p       (reset_p),
    .ch_req        (ch_req),
    .ch_len        (ch_len),
    .ch_port       (ch_port),
    .ch_dat        (ch_dat),
    .ch_rd         (ch_rd),
    .ch_start      (ch_start),
    .ch_done       (ch_done),
    .ch_err        (ch_err),
    .tx_en_pulse   (tx_en_pulse),
    .data_length   (data_length),
    .dst_port      (dst_port),
    .payload_req_i (payload_req_i),
    .payload_dat_o (payload_dat_o),
    .tx_done       (tx_done),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'b0, busy, tx_en_pulse, data_length, dst_port,
            ch_start, ch_done, ch_err, ch_rd, payload_dat_o};
  endfunction

  task automatic set_ch(input int ch, input int len, input logic [15:0] port);
    ch_len[16*ch +: 16]  = 16'(len);
    ch_port[16*ch +: 16] = port;
  endtask

  task automatic push(input int ch, input int len, input logic [15:0] port);
    launch_t e;
    e.ch = ch;
    e.len = len;
    e.port = port;
    sb.push_back(e);
  endtask

  // Wait for tx_en_pulse and compare the launch against the oldest expected entry.
  task automatic wait_launch(input int bound, output int waited);
    launch_t e;
    bit      seen;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < bound) begin
      @(negedge clk125m);
      waited++;
      if (tx_en_pulse) seen = 1'b1;
    end
    check("launch_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("sb_pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ch_start", 64'(ch_start), 64'd1 << e.ch);
        check("data_length", 64'(data_length), 64'(e.len));
        check("dst_port", 64'(dst_port), 64'(e.port));
        check("busy_launch", 64'(busy), 64'd1);
      end
    end
  endtask

  // Engine model: request len bytes, then pulse tx_done. d_cyc is the tx_done cycle.
  task automatic serve(input int ch, input int len, input bit drop_req, output int d_cyc);
    int         rd_cnt;
    logic [7:0] first_byte;
    rd_cnt     = 0;
    first_byte = 8'h00;
    @(negedge clk125m);
    if (drop_req) ch_req[ch] = 1'b0;
    for (int i = 0; i < len; i++) begin
      payload_req_i = 1'b1;
      #1;
      if (ch_rd == 4'(1 << ch)) rd_cnt++;
      if (i == 0) first_byte = payload_dat_o;
      @(negedge clk125m);
    end
    payload_req_i = 1'b0;
    #1;
    check("rd_count", 64'(rd_cnt), 64'(len));
    check("rd_idle", 64'(ch_rd), 64'd0);
    check("payload_byte", 64'(first_byte), 64'(ch_dat[8*ch +: 8]));
    check("len_held", 64'(data_length), 64'(len));
    d_cyc   = cyc;
    tx_done = 1'b1;
    @(negedge clk125m);
    tx_done = 1'b0;
    check("ch_done", 64'(ch_done), 64'd1 << ch);
    check("busy_gap", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk125m);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  initial begin
    int      w, d, n;
    bit      seen;
    int      exp_len[4];
    logic [15:0] exp_port[4];

    ch_req        = '0;
    ch_len        = '0;
    ch_port       = '0;
    ch_dat        = 32'hD3C2_B1A0;
    payload_req_i = 1'b0;
    tx_done       = 1'b0;
    d             = 0;

    // Reset state
    repeat (2) @(negedge clk125m);
    check("reset_outputs", outs(), 64'd0);
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    reset_p = 1'b0;
    @(negedge clk125m);

    // Illegal lengths on ch1 (0) and ch3 (1500)
    set_ch(1, 0, 16'h1111);
    set_ch(3, 1500, 16'h3333);
    ch_req = 4'b1010;
    @(negedge clk125m);
    check("err_first", 64'(ch_err), 64'b0010);
    check("err_first_no_launch", 64'(tx_en_pulse), 64'd0);
    ch_req[1] = 1'b0;
    @(negedge clk125m);
    check("err_second", 64'(ch_err), 64'b1000);
    ch_req[3] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk125m);
      if (tx_en_pulse || busy || ch_err != 4'b0) seen = 1'b1;
    end
    check("reject_quiet", 64'(seen), 64'd0);
    check("reject_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    // All four requesting: grant order 0,1,2,3,0 with exact IFG spacing
    exp_len  = '{1, 5, 1472, 7};
    exp_port = '{16'h0400, 16'h0401, 16'h0402, 16'h0403};
    for (int c = 0; c < 4; c++) set_ch(c, exp_len[c], exp_port[c]);
    for (int f = 0; f < 5; f++) push(f % 4, exp_len[f % 4], exp_port[f % 4]);
    ch_req = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_launch(64, w);
      if (f == 0) check("rr_first_latency", 64'(w), 64'd1);
      else        check("ifg_spacing", 64'(cyc - d), 64'(IFG + 2));
      if (f == 4) ch_req = '0;
      serve(f % 4, exp_len[f % 4], 1'b0, d);
    end
    wait_idle(64, n);
    check("gap_len", 64'(n), 64'(IFG));

    // Single channel ch2, len 20, port 0x1F90
    set_ch(2, 20, 16'h1F90);
    push(2, 20, 16'h1F90);
    ch_req = 4'b0100;
    wait_launch(64, w);
    check("launch_latency", 64'(w), 64'd1);
    serve(2, 20, 1'b0, d);
    ch_req = '0;
    wait_idle(64, n);
    check("single_gap_len", 64'(n), 64'(IFG));

    // Timeout on ch0: no tx_done
    set_ch(0, 3, 16'h0050);
    push(0, 3, 16'h0050);
    ch_req = 4'b0001;
    wait_launch(64, w);
    n    = 0;
    seen = 1'b0;
    @(negedge clk125m);
    while (ch_err == 4'b0 && n < TMO + 10) begin
      if (ch_done != 4'b0) seen = 1'b1;
      @(negedge clk125m);
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(TMO));
    check("timeout_err", 64'(ch_err), 64'b0001);
    check("timeout_in_gap", 64'(busy), 64'd1);
    ch_req = '0;
    wait_idle(64, n);
    check("timeout_gap_len", 64'(n), 64'(IFG));
    check("timeout_no_done", 64'(seen), 64'd0);

    // Mid-frame request drop on ch0, then spurious tx_done in GAP
    set_ch(0, 4, 16'h0060);
    push(0, 4, 16'h0060);
    ch_req = 4'b0001;
    wait_launch(64, w);
    serve(0, 4, 1'b1, d);
    @(negedge clk125m);
    tx_done = 1'b1;
    @(negedge clk125m);
    tx_done = 1'b0;
    check("spurious_done", 64'({ch_done, ch_err}), 64'd0);
    wait_idle(64, n);
    check("spurious_gap_len", 64'(n), 64'(IFG - 2));

    // Asynchronous reset during BUSY, then ch3 launches from rr_ptr 0
    set_ch(1, 10, 16'h0070);
    push(1, 10, 16'h0070);
    ch_req = 4'b0010;
    wait_launch(64, w);
    @(negedge clk125m);
    payload_req_i = 1'b1;
    repeat (3) @(negedge clk125m);
    #1;
    check("pre_reset_rd", 64'(ch_rd), 64'b0010);
    #1;
    reset_p = 1'b1;
    #1;
    check("reset_async", outs(), 64'd0);
    @(negedge clk125m);
    reset_p       = 1'b0;
    payload_req_i = 1'b0;
    ch_req        = '0;
    check("reset_rr_back", 64'(dut.rr_ptr), 64'd0);
    @(negedge clk125m);
    check("post_reset_quiet", outs(), 64'd0);
    set_ch(3, 8, 16'h0080);
    push(3, 8, 16'h0080);
    ch_req = 4'b1000;
    wait_launch(64, w);
    check("post_reset_latency", 64'(w), 64'd1);
    serve(3, 8, 1'b0, d);
    ch_req = '0;
    wait_idle(64, n);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
